// File: rtl/bp_fe_fetch_queue_pkg.sv
// Shared types for the front-end fetch queue: packet message kinds and parameter lookups.
// No logic; the lookups are elaboration-time constant functions.
// No flow control lives here.
package bp_fe_fetch_queue_pkg;

  // Packet type carried alongside each fetch; anything other than e_fe_fetch is an exception.
  typedef enum logic [1:0] {
    e_fe_fetch              = 2'd0,
    e_fe_itlb_miss          = 2'd1,
    e_fe_instr_page_fault   = 2'd2,
    e_fe_instr_access_fault = 2'd3
  } bp_fe_queue_msg_e;

  // Processor configurations understood by this block.
  typedef enum logic [0:0] {
    e_bp_default_cfg = 1'b0
  } bp_params_e;

  localparam int instr_width_gp = 32;

  function automatic int vaddr_width_f(input bp_params_e cfg);
    int w;
    case (cfg)
      e_bp_default_cfg: w = 39;
      default:          w = 39;
    endcase
    return w;
  endfunction

  function automatic int branch_metadata_fwd_width_f(input bp_params_e cfg);
    int w;
    case (cfg)
      e_bp_default_cfg: w = 36;
      default:          w = 36;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/bsg_mem_1r1w.sv
// One-write one-read register-file storage, no reset on contents.
// Write lands on posedge; read is asynchronous (zero latency from address).
// No backpressure: caller guarantees writes only to free slots.
module bsg_mem_1r1w #(
  parameter int width_p = 8,
  parameter int els_p   = 4,
  localparam int addr_width_lp = $clog2(els_p)
) (
  input  logic                     clk_i,
  input  logic                     w_v_i,
  input  logic [addr_width_lp-1:0] w_addr_i,
  input  logic [width_p-1:0]       w_data_i,
  input  logic [addr_width_lp-1:0] r_addr_i,
  output logic [width_p-1:0]       r_data_o
);

  logic [width_p-1:0] mem_q [els_p];

  // Capture the write data into the addressed slot.
  always_ff @(posedge clk_i) begin
    if (w_v_i) begin
      mem_q[w_addr_i] <= w_data_i;
    end
  end

  assign r_data_o = mem_q[r_addr_i];

endmodule

// File: rtl/bp_fe_fetch_queue.sv
// Fetch packet queue between the front end and the backend, with exception lock.
// Enqueue-to-v_o latency 1 cycle; head fields are read combinationally.
// ready_o drops when full or while an exception packet is held; no full-with-dequeue bypass.
module bp_fe_fetch_queue
  import bp_fe_fetch_queue_pkg::*;
#(
  parameter bp_params_e bp_params_p = e_bp_default_cfg,
  parameter int els_p = 4,
  localparam int vaddr_width_p = vaddr_width_f(bp_params_p),
  localparam int branch_metadata_fwd_width_p = branch_metadata_fwd_width_f(bp_params_p),
  localparam int count_width_lp = $clog2(els_p+1)
) (
  input  logic                                   clk_i,
  input  logic                                   reset_i,
  input  logic                                   clear_i,
  input  logic                                   v_i,
  output logic                                   ready_o,
  input  logic [vaddr_width_p-1:0]               pc_i,
  input  logic [instr_width_gp-1:0]              instr_i,
  input  logic [branch_metadata_fwd_width_p-1:0] br_metadata_fwd_i,
  input  bp_fe_queue_msg_e                       msg_i,
  output logic                                   v_o,
  output logic [vaddr_width_p-1:0]               pc_o,
  output logic [instr_width_gp-1:0]              instr_o,
  output logic [branch_metadata_fwd_width_p-1:0] br_metadata_fwd_o,
  output bp_fe_queue_msg_e                       msg_o,
  input  logic                                   yumi_i,
  output logic [count_width_lp-1:0]              count_o,
  output logic                                   locked_o
);

  localparam int addr_width_lp  = $clog2(els_p);
  localparam int ptr_width_lp   = addr_width_lp + 1;
  localparam int entry_width_lp = vaddr_width_p + instr_width_gp + branch_metadata_fwd_width_p + 2;

  localparam logic [0:0] e_normal = 1'b0;
  localparam logic [0:0] e_locked = 1'b1;

  typedef struct packed {
    logic [vaddr_width_p-1:0]               pc;
    logic [instr_width_gp-1:0]              instr;
    logic [branch_metadata_fwd_width_p-1:0] br_metadata_fwd;
    bp_fe_queue_msg_e                       msg;
  } entry_s;

  // Pointers carry one extra MSB so equal low bits with differing MSB means full.
  logic [ptr_width_lp-1:0] rptr_q, rptr_d;
  logic [ptr_width_lp-1:0] wptr_q, wptr_d;
  logic [0:0]              state_q, state_d;

  logic   empty, full, locked;
  logic   enq, deq;
  entry_s wr_entry, rd_entry;
  logic [entry_width_lp-1:0] rd_data;

  assign empty  = (rptr_q == wptr_q);
  assign full   = (rptr_q[addr_width_lp-1:0] == wptr_q[addr_width_lp-1:0])
                & (rptr_q[addr_width_lp] != wptr_q[addr_width_lp]);
  assign locked = (state_q == e_locked);

  assign ready_o  = ~full & ~locked;
  assign v_o      = ~empty;
  assign locked_o = locked;
  assign count_o  = count_width_lp'(wptr_q - rptr_q);

  // A flush wins over both handshakes, so neither side sees a transfer that cycle.
  assign enq = v_i & ready_o & ~clear_i;
  assign deq = yumi_i & v_o & ~clear_i;

  assign wr_entry.pc              = pc_i;
  assign wr_entry.instr           = instr_i;
  assign wr_entry.br_metadata_fwd = br_metadata_fwd_i;
  assign wr_entry.msg             = msg_i;

  bsg_mem_1r1w #(
    .width_p (entry_width_lp),
    .els_p   (els_p)
  ) mem (
    .clk_i    (clk_i),
    .w_v_i    (enq),
    .w_addr_i (wptr_q[addr_width_lp-1:0]),
    .w_data_i (wr_entry),
    .r_addr_i (rptr_q[addr_width_lp-1:0]),
    .r_data_o (rd_data)
  );

  assign rd_entry          = entry_s'(rd_data);
  assign pc_o              = rd_entry.pc;
  assign instr_o           = rd_entry.instr;
  assign br_metadata_fwd_o = rd_entry.br_metadata_fwd;
  assign msg_o             = rd_entry.msg;

  // Next pointers and lock state: flush collapses the queue, an accepted exception locks it.
  always_comb begin
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    state_d = state_q;
    if (clear_i) begin
      rptr_d  = wptr_q;
      state_d = e_normal;
    end else begin
      if (enq) begin
        wptr_d = wptr_q + ptr_width_lp'(1);
      end
      if (deq) begin
        rptr_d = rptr_q + ptr_width_lp'(1);
      end
      if (enq && (msg_i != e_fe_fetch)) begin
        state_d = e_locked;
      end
    end
  end

  // Register pointers and lock state; reset overrides a concurrent flush.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      state_q <= e_normal;
    end else begin
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      state_q <= state_d;
    end
  end

  // The backend must only consume when a head entry is presented.
  yumi_without_valid: assert property (@(posedge clk_i) disable iff (reset_i) yumi_i |-> v_o);

endmodule

// File: tb/tb_bp_fe_fetch_queue.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based model.
// Outputs sampled on the falling edge; model advanced on each rising edge.
// Stimulus only asserts yumi_i when the model holds an entry.
module tb_bp_fe_fetch_queue;
  import bp_fe_fetch_queue_pkg::*;

  localparam int ELS = 4;
  localparam int VW  = vaddr_width_f(e_bp_default_cfg);
  localparam int BW  = branch_metadata_fwd_width_f(e_bp_default_cfg);
  localparam int CW  = $clog2(ELS+1);

  logic                      clk_i = 1'b0;
  logic                      reset_i, clear_i, v_i, yumi_i;
  logic                      ready_o, v_o, locked_o;
  logic [VW-1:0]             pc_i, pc_o;
  logic [instr_width_gp-1:0] instr_i, instr_o;
  logic [BW-1:0]             br_metadata_fwd_i, br_metadata_fwd_o;
  bp_fe_queue_msg_e          msg_i, msg_o;
  logic [CW-1:0]             count_o;

  bp_fe_fetch_queue #(.bp_params_p(e_bp_default_cfg), .els_p(ELS)) dut (
    .clk_i             (clk_i),
    .reset_i           (reset_i),
    .clear_i           (clear_i),
    .v_i               (v_i),
    .ready_o           (ready_o),
    .pc_i              (pc_i),
    .instr_i           (instr_i),
    .br_metadata_fwd_i (br_metadata_fwd_i),
    .msg_i             (msg_i),
    .v_o               (v_o),
    .pc_o              (pc_o),
    .instr_o           (instr_o),
    .br_metadata_fwd_o (br_metadata_fwd_o),
    .msg_o             (msg_o),
    .yumi_i            (yumi_i),
    .count_o           (count_o),
    .locked_o          (locked_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [VW-1:0]             pc;
    logic [instr_width_gp-1:0] instr;
    logic [BW-1:0]             md;
    bp_fe_queue_msg_e          msg;
  } ent_t;

  // Reference model: a plain FIFO of packets plus a lock flag.
  ent_t mq[$];
  logic mlocked;

  int n_vec = 0;
  int n_miscmp = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, compare outputs with the model, then advance the model.
  task automatic cyc(input logic v, input logic [VW-1:0] pc, input bp_fe_queue_msg_e msg,
                     input logic yumi, input logic clr, input logic rst);
    ent_t e;
    logic can_enq;
    e.pc    = pc;
    e.instr = $urandom;
    e.md    = BW'({$urandom, $urandom});
    e.msg   = msg;
    v_i = v; pc_i = pc; instr_i = e.instr; br_metadata_fwd_i = e.md; msg_i = msg;
    yumi_i = yumi; clear_i = clr; reset_i = rst;
    @(negedge clk_i);
    check("v_o",      64'(v_o),      64'(mq.size() != 0));
    check("ready_o",  64'(ready_o),  64'((mq.size() < ELS) && !mlocked));
    check("count_o",  64'(count_o),  64'(mq.size()));
    check("locked_o", 64'(locked_o), 64'(mlocked));
    if (mq.size() != 0) begin
      check("pc_o",    64'(pc_o),              64'(mq[0].pc));
      check("instr_o", 64'(instr_o),           64'(mq[0].instr));
      check("md_o",    64'(br_metadata_fwd_o), 64'(mq[0].md));
      check("msg_o",   64'(msg_o),             64'(mq[0].msg));
    end
    can_enq = v && (mq.size() < ELS) && !mlocked;
    @(posedge clk_i);
    if (rst || clr) begin
      mq.delete();
      mlocked = 1'b0;
    end else begin
      if (yumi && mq.size() != 0) void'(mq.pop_front());
      if (can_enq) begin
        mq.push_back(e);
        if (msg != e_fe_fetch) mlocked = 1'b1;
      end
    end
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, '0, e_fe_fetch, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    reset_i = 1'b1; clear_i = 1'b0; v_i = 1'b0; yumi_i = 1'b0;
    pc_i = '0; instr_i = '0; br_metadata_fwd_i = '0; msg_i = e_fe_fetch;
    mlocked = 1'b0;
    repeat (3) @(posedge clk_i);
    #1 reset_i = 1'b0;

    // Reset state, then fill to full; v_o must rise the cycle after the first enqueue.
    for (int i = 0; i < 4; i++) cyc(1'b1, VW'(32'h8000_0000 + 4*i), e_fe_fetch, 1'b0, 1'b0, 1'b0);
    check("full_count", 64'(count_o), 64'd4);
    check("full_ready", 64'(ready_o), 64'd0);
    for (int i = 0; i < 4; i++) begin
      check("drain_pc", 64'(pc_o), 64'(32'h8000_0000 + 4*i));
      cyc(1'b0, '0, e_fe_fetch, 1'b1, 1'b0, 1'b0);
    end
    check("drained_v", 64'(v_o), 64'd0);
    idle();

    // Steady occupancy 2 with simultaneous push/pop across pointer wrap.
    for (int i = 0; i < 2; i++) cyc(1'b1, VW'(32'h2000 + 4*i), e_fe_fetch, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, VW'(32'h2008 + 4*i), e_fe_fetch, 1'b1, 1'b0, 1'b0);
      check("steady_count", 64'(count_o), 64'd2);
    end
    for (int i = 0; i < 2; i++) cyc(1'b0, '0, e_fe_fetch, 1'b1, 1'b0, 1'b0);

    // Flush at occupancy 3 with concurrent enqueue and dequeue.
    for (int i = 0; i < 3; i++) cyc(1'b1, VW'(32'h3000 + 4*i), e_fe_fetch, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, VW'(32'hDEAD_0000), e_fe_fetch, 1'b1, 1'b1, 1'b0);
    check("clear_v", 64'(v_o), 64'd0);
    check("clear_count", 64'(count_o), 64'd0);
    idle();

    // Exception lock: drains in order, held off until flushed.
    cyc(1'b1, VW'(32'h1000), e_fe_fetch, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, VW'(32'h1004), e_fe_itlb_miss, 1'b0, 1'b0, 1'b0);
    check("lock_locked", 64'(locked_o), 64'd1);
    check("lock_ready", 64'(ready_o), 64'd0);
    check("lock_pc0", 64'(pc_o), 64'h1000);
    cyc(1'b1, VW'(32'h1008), e_fe_fetch, 1'b1, 1'b0, 1'b0);
    check("lock_pc1", 64'(pc_o), 64'h1004);
    cyc(1'b0, '0, e_fe_fetch, 1'b1, 1'b0, 1'b0);
    idle();
    cyc(1'b0, '0, e_fe_fetch, 1'b0, 1'b1, 1'b0);
    check("unlock_locked", 64'(locked_o), 64'd0);
    check("unlock_ready", 64'(ready_o), 64'd1);
    idle();

    // Reset while full and locked.
    for (int i = 0; i < 3; i++) cyc(1'b1, VW'(32'h4000 + 4*i), e_fe_fetch, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, VW'(32'h400C), e_fe_instr_page_fault, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, '0, e_fe_fetch, 1'b0, 1'b0, 1'b1);
    check("rst_count", 64'(count_o), 64'd0);
    check("rst_locked", 64'(locked_o), 64'd0);
    check("rst_ready", 64'(ready_o), 64'd1);
    check("rst_v", 64'(v_o), 64'd0);
    idle();

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      logic rv, ry, rc, rr;
      bp_fe_queue_msg_e rm;
      rv = ($urandom_range(0, 3) != 0);
      ry = ($urandom_range(0, 2) != 0) && (mq.size() != 0);
      rc = ($urandom_range(0, 39) == 0);
      rr = ($urandom_range(0, 299) == 0);
      rm = ($urandom_range(0, 19) == 0) ? bp_fe_queue_msg_e'($urandom_range(1, 3)) : e_fe_fetch;
      cyc(rv, VW'({$urandom, $urandom}), rm, ry, rc, rr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
